// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory responder and its RAM.
package dmem_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BE_W        = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned LAT_W       = 4;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request fields captured at accept; the word index is kept apart since its width is a parameter.
    typedef struct packed {
        logic              is_write;
        logic              err;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: byte-enabled synchronous write, registered read that can be forced to zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rclr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read register holds between reads so the last load stays visible.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rclr ? '0 : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the CPU load/store port.
// Define DMEM_STATS_EN to add saturating read/write/error response counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
`ifdef DMEM_STATS_EN
   ,output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    req_s              req_q, req_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              req_err_c;
    logic              enter_resp_c;

    assign req_err_c = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);

    // Next state, request capture and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        widx_d  = widx_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.is_write = req_write;
                    req_d.err      = req_err_c;
                    req_d.be       = req_be;
                    req_d.wdata    = req_wdata;
                    widx_d         = req_addr[ADDR_W+1:2];
                    cnt_d          = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q <= LAT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // req_d already carries the live request when a single-cycle latency accepts straight into RESP.
    assign enter_resp_c = (state_d == RESP) && (state_q != RESP) && !reset;

    always_comb begin
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        err_d   = (state_d == RESP) && req_d.err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            widx_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            widx_q  <= widx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (enter_resp_c && req_d.is_write && !req_d.err),
        .be    (req_d.be),
        .addr  (widx_d),
        .wdata (req_d.wdata),
        .re    (enter_resp_c),
        .rclr  (req_d.is_write || req_d.err),
        .rdata (resp_rdata)
    );

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;

`ifdef DMEM_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] er_cnt_q, er_cnt_d;

    // Each response lands in exactly one bucket; errors take precedence over direction.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        er_cnt_d = er_cnt_q;
        if (state_q == RESP) begin
            if (req_q.err) begin
                er_cnt_d = sat_inc(er_cnt_q);
            end else if (req_q.is_write) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
                rd_cnt_d = sat_inc(rd_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = er_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a timeline/array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 1 << AW;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count, wr_count, err_count;
    logic [15:0] m_rd = '0, m_wr = '0, m_er = '0;
`endif

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int rsp_n   = 0;
    logic [31:0] got_rdata = '0;
    logic        got_err   = 1'b0;

    // Reference model state
    logic [31:0] mmem [WORDS];
    bit          model_on  = 1'b0;
    bit          pend      = 1'b0;
    int          pend_edge = 0;
    int          free_edge = 0;
    bit          p_write, p_err;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    int unsigned p_idx;
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;

    dmem_responder #(
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
`ifdef DMEM_STATS_EN
       ,.rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Model: an accept at edge n commits at edge n+LAT-1 and frees the port at edge n+LAT+1.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            model_on  = 1'b1;
            pend      = 1'b0;
            free_edge = cyc + 1;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_rdata = '0;
            exp_ready = 1'b1;
`ifdef DMEM_STATS_EN
            m_rd = '0; m_wr = '0; m_er = '0;
`endif
        end else if (model_on) begin
`ifdef DMEM_STATS_EN
            if (exp_valid) begin
                if (exp_err)      m_er = (m_er == 16'hFFFF) ? m_er : m_er + 16'd1;
                else if (p_write) m_wr = (m_wr == 16'hFFFF) ? m_wr : m_wr + 16'd1;
                else              m_rd = (m_rd == 16'hFFFF) ? m_rd : m_rd + 16'd1;
            end
`endif
            if (cyc >= free_edge && req_valid) begin
                pend      = 1'b1;
                pend_edge = cyc + int'(LAT) - 1;
                free_edge = cyc + int'(LAT) + 1;
                p_write   = req_write;
                p_wdata   = req_wdata;
                p_be      = req_be;
                p_err     = (req_addr % 32'd4 != 32'd0) || (req_addr >= 32'(4 * WORDS));
                p_idx     = req_addr / 32'd4;
            end
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (pend && cyc == pend_edge) begin
                pend = 1'b0;
                if (p_write && !p_err) mmem[p_idx] = merge(mmem[p_idx], p_wdata, p_be);
                exp_rdata = (p_write || p_err) ? 32'd0 : mmem[p_idx];
                exp_valid = 1'b1;
                exp_err   = p_err;
            end
            exp_ready = (cyc + 1 >= free_edge);
        end
    end

    // Compare every cycle once reset has been seen; also capture responses for directed checks.
    always @(negedge clk) begin
        if (model_on) begin
            check("req_ready",  32'(req_ready),  32'(exp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("resp_err",   32'(resp_err),   32'(exp_err));
            check("resp_rdata", resp_rdata,      exp_rdata);
`ifdef DMEM_STATS_EN
            check("rd_count",  32'(rd_count),  32'(m_rd));
            check("wr_count",  32'(wr_count),  32'(m_wr));
            check("err_count", 32'(err_count), 32'(m_er));
`endif
            if (resp_valid) begin
                rsp_cyc   = cyc;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                rsp_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and hold it until the DUT takes it.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        int  waited;
        logic took;
        waited    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        do begin
            took = req_ready;
            step(1);
            waited++;
        end while (!took && waited < 40);
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 40 cycles (addr %h)", a);
        end
        acc_cyc = cyc;
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
        int n0;
        int k;
        n0 = rsp_n;
        k  = 0;
        issue(w, a, d, be);
        req_valid = 1'b0;
        while (rsp_n == n0 && k < 40) begin
            step(1);
            k++;
        end
        if (rsp_n == n0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no response expected one within 40 cycles (addr %h)", a);
        end
        rd  = got_rdata;
        er  = got_err;
        lat = rsp_cyc - acc_cyc + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          a0, a1, a2, n0, r;
        logic [31:0] a;

        step(3);
        check("reset_req_ready",  32'(req_ready),  32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata,      32'd0);
        check("reset_resp_err",   32'(resp_err),   32'd0);
        reset = 1'b0;

        for (int i = 0; i < int'(WORDS); i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);
        req_valid = 1'b0;
        step(LAT + 1);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("store_err", 32'(er), 32'd0);
        check("store_latency", 32'(lat), 32'd2);
        check("store_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("load_rdata", rd, 32'hDEADBEEF);
        check("load_err", 32'(er), 32'd0);

        txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("be_merge", rd, 32'h11BB33DD);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check("be_zero_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("be_zero_nochange", rd, 32'h11BB33DD);

        txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        check("misaligned_err", 32'(er), 32'd1);
        check("misaligned_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
        txn(1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
        check("range_err", 32'(er), 32'd1);
        check("range_latency", 32'(lat), 32'd2);
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        check("range_nowrite", rd, 32'hCAFEF00D);
        txn(1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, rd, er, lat);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        check("top_word", rd, 32'h0BADF00D);
        check("top_word_err", 32'(er), 32'd0);

        issue(1'b0, 32'h10, 32'h0, 4'h0); a0 = acc_cyc;
        issue(1'b0, 32'h20, 32'h0, 4'h0); a1 = acc_cyc;
        issue(1'b0, 32'h0,  32'h0, 4'h0); a2 = acc_cyc;
        req_valid = 1'b0;
        check("b2b_gap1", 32'(a1 - a0), 32'd3);
        check("b2b_gap2", 32'(a2 - a1), 32'd3);
        step(LAT + 1);
        check("b2b_last_rdata", got_rdata, 32'hCAFEF00D);

        txn(1'b1, 32'h30, 32'h01020304, 4'hF, rd, er, lat);
        issue(1'b1, 32'h30, 32'h5A5A5A5A, 4'hF);
        n0        = rsp_n;
        req_valid = 1'b0;
        reset     = 1'b1;
        step(1);
        reset = 1'b0;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        step(LAT + 2);
        check("no_resp_after_reset", 32'(rsp_n), 32'(n0));
        txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        check("reset_drop_store", rd, 32'h01020304);

`ifdef DMEM_STATS_EN
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        txn(1'b0, 32'h0,  32'h0, 4'h0, rd, er, lat);
        txn(1'b0, 32'h4,  32'h0, 4'h0, rd, er, lat);
        txn(1'b1, 32'h8,  32'h77777777, 4'hF, rd, er, lat);
        txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        check("stats_rd",  32'(rd_count),  32'd2);
        check("stats_wr",  32'(wr_count),  32'd1);
        check("stats_err", 32'(err_count), 32'd1);
`endif

        for (int t = 0; t < 400; t++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = 32'($urandom_range(0, WORDS - 1) * 4) | 32'($urandom_range(1, 3));
            else if (r == 1) a = $urandom | 32'h0000_0400;
            else             a = 32'($urandom_range(0, WORDS - 1) * 4);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 24) == 0) begin
                req_valid = 1'b0;
                reset     = 1'b1;
                step(1);
                reset = 1'b0;
            end else begin
                r = int'($urandom_range(0, 2));
                if (r != 0) begin
                    req_valid = 1'b0;
                    step(r);
                end
            end
        end
        req_valid = 1'b0;
        step(LAT + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
